// File: rtl/trng_pool_if.sv
// trng_pool_if: raw TRNG word handshake plus packed-word ready/valid port.
// master = the entropy pool, slave = the environment (TRNG source and consumer).
interface trng_pool_if #(
  parameter int TRNG_WIDTH = 8,
  parameter int OUT_WIDTH  = 32
);
  logic [TRNG_WIDTH-1:0] trng_word;
  logic                  trng_valid;
  logic                  trng_req;
  logic [OUT_WIDTH-1:0]  out_data;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    input  trng_word, trng_valid, out_ready,
    output trng_req, out_data, out_valid
  );

  modport slave (
    output trng_word, trng_valid, out_ready,
    input  trng_req, out_data, out_valid
  );
endinterface

// File: rtl/trng_pool.sv
// trng_pool: packs TRNG_WIDTH-bit raw entropy words little-endian into
// OUT_WIDTH-bit words, buffers them in a first-word-fall-through FIFO and
// hands them out over ready/valid. Supports synchronous flush.
// Optional repetition-count health test enabled by defining TRNG_POOL_HEALTH_EN;
// without it health_fail is tied low.
module trng_pool #(
  parameter int TRNG_WIDTH = 8,
  parameter int OUT_WIDTH  = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int REP_LIMIT  = 16
) (
  input  logic                          clk,
  input  logic                          resetn,
  trng_pool_if.master                   bus,
  input  logic                          flush,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          health_fail
);

  localparam int K  = OUT_WIDTH / TRNG_WIDTH;
  localparam int CW = (K > 1) ? $clog2(K) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  // Elaboration-time parameter sanity
  if ((OUT_WIDTH % TRNG_WIDTH) != 0 || OUT_WIDTH < TRNG_WIDTH) begin : g_bad_width
    $error("trng_pool: OUT_WIDTH must be a positive multiple of TRNG_WIDTH");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("trng_pool: FIFO_DEPTH must be a power of two >= 2");
  end
  if (REP_LIMIT < 2) begin : g_bad_rep
    $error("trng_pool: REP_LIMIT must be >= 2");
  end

  logic [OUT_WIDTH-1:0]  mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [LW-1:0]         lvl;
  logic [CW-1:0]         cnt;
  logic [OUT_WIDTH-1:0]  pack;
  logic [OUT_WIDTH-1:0]  pack_nxt;
  logic                  req_en;
  logic                  hf;
  logic                  full;
  logic                  empty;
  logic                  accept;
  logic                  rep_trip;
  logic                  take;
  logic                  push;
  logic                  pop;

  // trng_req depends only on registered state and flush; req_en holds it low
  // until the first edge after reset release.
  assign full         = (lvl == LW'(FIFO_DEPTH));
  assign empty        = (lvl == '0);
  assign bus.trng_req = req_en && !full && !flush && !hf;
  assign accept       = bus.trng_req && bus.trng_valid;
  assign take         = accept && !rep_trip;
  assign push         = take && (cnt == CW'(K - 1));
  assign pop          = !empty && bus.out_ready && !flush;

  assign bus.out_valid = !empty;
  assign bus.out_data  = empty ? '0 : mem[rd_ptr];
  assign level         = lvl;
  assign health_fail   = hf;

  // Insert the incoming raw word into its little-endian slot of the pack
  always_comb begin
    pack_nxt = pack;
    pack_nxt[int'(cnt) * TRNG_WIDTH +: TRNG_WIDTH] = bus.trng_word;
  end

  // Pack counter, FIFO pointers and occupancy; flush overrides push and pop
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      req_en <= 1'b0;
      lvl    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      pack   <= '0;
    end else begin
      req_en <= 1'b1;
      if (flush) begin
        lvl    <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt    <= '0;
        pack   <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        case ({push, pop})
          2'b10:   lvl <= lvl + LW'(1);
          2'b01:   lvl <= lvl - LW'(1);
          default: lvl <= lvl;
        endcase
        if (rep_trip) begin
          cnt <= '0;
        end else if (take) begin
          pack <= pack_nxt;
          cnt  <= push ? '0 : cnt + CW'(1);
        end
      end
    end
  end

  // FIFO storage: completed pack written at the tail
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= pack_nxt;
  end

`ifdef TRNG_POOL_HEALTH_EN
  localparam int RW = $clog2(REP_LIMIT + 1);

  logic [TRNG_WIDTH-1:0] prev_word;
  logic [RW-1:0]         run_cnt;
  logic [RW-1:0]         run_nxt;

  // run_cnt==0 means no previous word since reset/flush
  always_comb begin
    run_nxt  = ((run_cnt != '0) && (bus.trng_word == prev_word)) ? run_cnt + RW'(1) : RW'(1);
    rep_trip = accept && (run_nxt == RW'(REP_LIMIT));
  end

  // Run length and sticky failure flag; flush re-arms the test
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      run_cnt <= '0;
      hf      <= 1'b0;
    end else if (flush) begin
      run_cnt <= '0;
      hf      <= 1'b0;
    end else if (accept) begin
      run_cnt <= run_nxt;
      if (rep_trip) hf <= 1'b1;
    end
  end

  // Last accepted raw word, reference for the repetition compare
  always_ff @(posedge clk) begin
    if (accept) prev_word <= bus.trng_word;
  end
`else
  assign rep_trip = 1'b0;
  assign hf       = 1'b0;
`endif

endmodule

// File: tb/tb_trng_pool.sv
// tb_trng_pool: scenario-per-task bench for trng_pool (default parameters).
// A reference model packs driven bytes and pushes expected words into a
// scoreboard queue; words are popped and compared as the DUT delivers them.
module tb_trng_pool;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  level;
  logic        health_fail;

  trng_pool_if #(.TRNG_WIDTH(8), .OUT_WIDTH(32)) bus ();

  trng_pool u_dut (
    .clk         (clk),
    .resetn      (resetn),
    .bus         (bus.master),
    .flush       (flush),
    .level       (level),
    .health_fail (health_fail)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] sbq[$];
  logic [31:0] mpack = '0;
  int          mcnt = 0;
  int          mlevel = 0;
  logic        mhf = 1'b0;
  logic [7:0]  mprev = '0;
  int          mrun = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    sbq.delete();
    mpack = '0;
    mcnt = 0;
    mlevel = 0;
    mhf = 1'b0;
    mrun = 0;
  endtask

  // Drive one byte for one edge (trng_valid left high); update the model if it
  // should be accepted.
  task automatic send_byte(input logic [7:0] b);
    bit acc;
    acc = (mlevel < 4) && !mhf;
    bus.trng_word = b;
    bus.trng_valid = 1'b1;
    tick();
    if (acc) begin
`ifdef TRNG_POOL_HEALTH_EN
      mrun = (mrun != 0 && b == mprev) ? mrun + 1 : 1;
      mprev = b;
      if (mrun == 16) begin
        mhf = 1'b1;
        mcnt = 0;
        return;
      end
`endif
      mpack[mcnt*8 +: 8] = b;
      if (mcnt == 3) begin
        sbq.push_back(mpack);
        mcnt = 0;
        mlevel++;
      end else begin
        mcnt++;
      end
    end
  endtask

  // Pop the head word; returns what out_data showed before the pop edge
  task automatic pop_word(output logic [31:0] got);
    bus.trng_valid = 1'b0;
    bus.out_ready = 1'b1;
    got = bus.out_data;
    tick();
    bus.out_ready = 1'b0;
    if (mlevel > 0) mlevel--;
  endtask

  task automatic test_reset();
    #12;
    n_cmp++; if (bus.trng_req !== 1'b0) begin n_err++; $display("FAIL rst_req: got %b want 0", bus.trng_req); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.out_data !== 32'h0) begin n_err++; $display("FAIL rst_data: got %h want 0", bus.out_data); end
    n_cmp++; if (level !== 3'd0) begin n_err++; $display("FAIL rst_level: got %0d want 0", level); end
    n_cmp++; if (health_fail !== 1'b0) begin n_err++; $display("FAIL rst_health: got %b want 0", health_fail); end
    tick();
    resetn = 1'b1;
    #1;
    n_cmp++; if (bus.trng_req !== 1'b0) begin n_err++; $display("FAIL rel_req_pre: got %b want 0", bus.trng_req); end
    tick();
    n_cmp++; if (bus.trng_req !== 1'b1) begin n_err++; $display("FAIL rel_req_post: got %b want 1", bus.trng_req); end
  endtask

  task automatic test_pack();
    logic [31:0] got, exp;
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL pack_early_valid: got %b want 0", bus.out_valid); end
    send_byte(8'h44);
    bus.trng_valid = 1'b0;
    n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL pack_valid: got %b want 1", bus.out_valid); end
    n_cmp++; if (bus.out_data !== 32'h44332211) begin n_err++; $display("FAIL pack_data: got %h want 44332211", bus.out_data); end
    n_cmp++; if (level !== 3'd1) begin n_err++; $display("FAIL pack_level: got %0d want 1", level); end
    pop_word(got);
    exp = sbq.pop_front();
    n_cmp++; if (got !== exp) begin n_err++; $display("FAIL pack_pop: got %h want %h", got, exp); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL pack_empty: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_full();
    logic [31:0] got, exp;
    for (int i = 0; i < 16; i++) send_byte(8'h30 + 8'(i));
    bus.trng_valid = 1'b0;
    n_cmp++; if (level !== 3'd4) begin n_err++; $display("FAIL full_level: got %0d want 4", level); end
    n_cmp++; if (bus.trng_req !== 1'b0) begin n_err++; $display("FAIL full_req: got %b want 0", bus.trng_req); end
    send_byte(8'hEE);
    bus.trng_valid = 1'b0;
    n_cmp++; if (level !== 3'd4) begin n_err++; $display("FAIL full_17th_level: got %0d want 4", level); end
    pop_word(got);
    exp = sbq.pop_front();
    n_cmp++; if (got !== exp) begin n_err++; $display("FAIL full_pop0: got %h want %h", got, exp); end
    n_cmp++; if (bus.trng_req !== 1'b1) begin n_err++; $display("FAIL full_req_after_pop: got %b want 1", bus.trng_req); end
    for (int i = 0; i < 4; i++) send_byte(8'hC0 + 8'(i));
    bus.trng_valid = 1'b0;
    n_cmp++; if (level !== 3'd4) begin n_err++; $display("FAIL full_refill_level: got %0d want 4", level); end
    for (int i = 0; i < 4; i++) begin
      pop_word(got);
      exp = sbq.pop_front();
      n_cmp++; if (got !== exp) begin n_err++; $display("FAIL full_drain%0d: got %h want %h", i, got, exp); end
    end
    n_cmp++; if (exp !== 32'hC3C2C1C0) begin n_err++; $display("FAIL full_fifth_word: got %h want c3c2c1c0", exp); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] got, exp;
    for (int i = 0; i < 8; i++) send_byte(8'h60 + 8'(i));
    for (int i = 0; i < 3; i++) send_byte(8'h80 + 8'(i));
    n_cmp++; if (level !== 3'd2) begin n_err++; $display("FAIL b2b_pre_level: got %0d want 2", level); end
    bus.out_ready = 1'b1;
    got = bus.out_data;
    send_byte(8'h83);
    bus.trng_valid = 1'b0;
    bus.out_ready = 1'b0;
    mlevel--;
    exp = sbq.pop_front();
    n_cmp++; if (got !== exp) begin n_err++; $display("FAIL b2b_pop_old: got %h want %h", got, exp); end
    n_cmp++; if (level !== 3'd2) begin n_err++; $display("FAIL b2b_level: got %0d want 2", level); end
    for (int i = 0; i < 2; i++) begin
      pop_word(got);
      exp = sbq.pop_front();
      n_cmp++; if (got !== exp) begin n_err++; $display("FAIL b2b_drain%0d: got %h want %h", i, got, exp); end
    end
  endtask

  task automatic test_flush();
    logic [31:0] got, exp;
    for (int i = 0; i < 6; i++) send_byte(8'h90 + 8'(i));
    bus.trng_valid = 1'b1;
    bus.trng_word = 8'hFF;
    flush = 1'b1;
    #1;
    n_cmp++; if (bus.trng_req !== 1'b0) begin n_err++; $display("FAIL flush_req: got %b want 0", bus.trng_req); end
    tick();
    flush = 1'b0;
    bus.trng_valid = 1'b0;
    model_clear();
    n_cmp++; if (level !== 3'd0) begin n_err++; $display("FAIL flush_level: got %0d want 0", level); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid: got %b want 0", bus.out_valid); end
    for (int i = 0; i < 4; i++) send_byte(8'hA0 + 8'(i));
    bus.trng_valid = 1'b0;
    n_cmp++; if (bus.out_data !== 32'hA3A2A1A0) begin n_err++; $display("FAIL flush_next: got %h want a3a2a1a0", bus.out_data); end
    pop_word(got);
    exp = sbq.pop_front();
    n_cmp++; if (got !== exp) begin n_err++; $display("FAIL flush_pop: got %h want %h", got, exp); end
  endtask

`ifdef TRNG_POOL_HEALTH_EN
  task automatic test_health();
    logic [31:0] got, exp;
    for (int i = 0; i < 16; i++) send_byte(8'h5A);
    bus.trng_valid = 1'b0;
    n_cmp++; if (health_fail !== 1'b1) begin n_err++; $display("FAIL hlth_flag: got %b want 1", health_fail); end
    n_cmp++; if (bus.trng_req !== 1'b0) begin n_err++; $display("FAIL hlth_req: got %b want 0", bus.trng_req); end
    n_cmp++; if (level !== 3'd3) begin n_err++; $display("FAIL hlth_level: got %0d want 3", level); end
    for (int i = 0; i < 3; i++) begin
      pop_word(got);
      exp = sbq.pop_front();
      n_cmp++; if (got !== 32'h5A5A5A5A) begin n_err++; $display("FAIL hlth_pop%0d: got %h want %h", i, got, exp); end
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    model_clear();
    n_cmp++; if (health_fail !== 1'b0) begin n_err++; $display("FAIL hlth_clear: got %b want 0", health_fail); end
    n_cmp++; if (bus.trng_req !== 1'b1) begin n_err++; $display("FAIL hlth_req_back: got %b want 1", bus.trng_req); end
  endtask
`endif

  task automatic test_async_reset();
    logic [31:0] got, exp;
    for (int i = 0; i < 14; i++) send_byte(8'hD0 + 8'(i));
    bus.trng_valid = 1'b0;
    n_cmp++; if (level !== 3'd3) begin n_err++; $display("FAIL arst_pre_level: got %0d want 3", level); end
    #2;
    resetn = 1'b0;
    #1;
    model_clear();
    n_cmp++; if (level !== 3'd0) begin n_err++; $display("FAIL arst_level: got %0d want 0", level); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL arst_valid: got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.out_data !== 32'h0) begin n_err++; $display("FAIL arst_data: got %h want 0", bus.out_data); end
    n_cmp++; if (bus.trng_req !== 1'b0) begin n_err++; $display("FAIL arst_req: got %b want 0", bus.trng_req); end
    tick();
    resetn = 1'b1;
    #1;
    n_cmp++; if (bus.trng_req !== 1'b0) begin n_err++; $display("FAIL arst_rel_pre: got %b want 0", bus.trng_req); end
    tick();
    n_cmp++; if (bus.trng_req !== 1'b1) begin n_err++; $display("FAIL arst_rel_post: got %b want 1", bus.trng_req); end
    for (int i = 0; i < 4; i++) send_byte(8'hE0 + 8'(i));
    bus.trng_valid = 1'b0;
    pop_word(got);
    exp = sbq.pop_front();
    n_cmp++; if (got !== 32'hE3E2E1E0 || got !== exp) begin n_err++; $display("FAIL arst_repack: got %h want %h", got, exp); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.trng_word = '0;
    bus.trng_valid = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_pack();
    test_full();
    test_back_to_back();
    test_flush();
`ifdef TRNG_POOL_HEALTH_EN
    test_health();
`endif
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
